hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. Detects load-use hazards against the ID/EX register and applies branch flushes driven by the execute stage's `br_taken`. Freezes the whole pipeline while the data-memory handshake is pending. Drives the stall/flush enables of the PC, IF/ID, ID/EX and EX/MEM registers, and watches memory-wait length with a watchdog.

## Interface
- `MEM_TIMEOUT`, default 255: max consecutive memory-wait cycles before the error flag sets (1..65535).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `id_rs1`, `id_rs2` input 5 each: source register indices of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` input 1 each: ID instruction actually reads rs1 / rs2.
- `ex_rd` input 5: destination index of the instruction in EX.
- `ex_mem_read` input 1: EX instruction is a load.
- `br_taken` input 1: branch decision from execute (combinational, same cycle).
- `mem_req` input 1: MEM-stage instruction is accessing data memory this cycle.
- `mem_ready` input 1: data memory completes the access this cycle.
- `pc_stall` output 1: hold PC.
- `if_id_stall` output 1: hold IF/ID.
- `id_ex_stall` output 1: hold ID/EX.
- `ex_mem_stall` output 1: hold EX/MEM.
- `if_id_flush` output 1: load bubble into IF/ID.
- `id_ex_flush` output 1: load bubble into ID/EX.
- `mem_timeout_err` output 1: sticky watchdog error.

## Operation
- States (`hz_state_e`): `HZ_RUN`, `HZ_MEM_WAIT`, `HZ_FLUSH`.
- Hazard priority, highest first: memory wait, then branch flush, then load-use.
- **Memory wait:** raised when `mem_req && !mem_ready` in any state.
  - All four stalls are 1; both flushes are 0; `br_taken` and load-use are ignored.
  - From `HZ_RUN` or `HZ_FLUSH`, next state is `HZ_MEM_WAIT`.
- **Release:** in `HZ_MEM_WAIT` with `mem_ready=1`, outputs are evaluated exactly as in `HZ_RUN`.
  - A branch held in EX during the wait is flushed on this release cycle.
  - Next state is `HZ_FLUSH` if `br_taken`, else `HZ_RUN`.
  - `mem_req=0` while in `HZ_MEM_WAIT` also counts as release.
- **Branch flush:** `br_taken=1` with no memory wait gives `if_id_flush=1`, `id_ex_flush=1`, all stalls 0. Next state is `HZ_FLUSH`.
- **`HZ_FLUSH`:** lasts one cycle. Load-use detection is suppressed because ID holds a bubble. A new `br_taken` is honoured as in RUN. Next state is `HZ_RUN` unless a memory wait or branch occurs.
- **Load-use:** in `HZ_RUN` or the release cycle, the hazard is `ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd))`.
  - Response: `pc_stall=1`, `if_id_stall=1`, `id_ex_flush=1`; other outputs 0.
  - Lasts one cycle only; no state change, because the load moves to MEM next cycle.
- **Watchdog:** a 16-bit counter increments each cycle the memory-wait condition holds and clears on any non-wait cycle.
  - When the counter reaches `MEM_TIMEOUT`, `mem_timeout_err` sets and stays 1 until `rst`.
  - The counter saturates at `MEM_TIMEOUT`.
  - Stalls continue; the error flag does not break the wait.

## Timing
- Stall and flush outputs are combinational from the current state plus the current inputs, with zero-cycle latency.
- State, watchdog counter and error flag are registered.
- While `rst=1`:
  - state is `HZ_RUN`, counter is 0, `mem_timeout_err=0`;
  - outputs are forced to `if_id_flush=1`, `id_ex_flush=1`, all stalls 0;
  - all performance counters are 0.
- Reset asserted mid-wait aborts the wait immediately; normal evaluation resumes the cycle after `rst` falls.
- `mem_ready=1` arriving in the same cycle as `mem_req` is not a wait: no stall, and the counter stays 0.
- Simultaneous `br_taken` and load-use gives the branch flush only; the load-use stall is dropped.
- `br_taken` together with a memory wait gives the stall only; the flush is deferred to the release cycle.

## Configuration
- Macro: `HAZARD_PERF_EN`.
- **Defined:** adds output ports `perf_stall_cycles` (32), `perf_flush_count` (32) and `perf_load_use_count` (32). All three are saturating counters, cleared by `rst`.
  - `perf_stall_cycles` increments on any cycle where `pc_stall=1`.
  - `perf_flush_count` increments on each branch flush cycle.
  - `perf_load_use_count` increments on each load-use stall cycle.
- **Undefined:** these ports and their logic are absent; all other behaviour is identical.

## Structure
- `control_pkg` gains:
  - `hz_state_e` (2-bit enum: `HZ_RUN=0`, `HZ_MEM_WAIT=1`, `HZ_FLUSH=2`);
  - constant `REG_ZERO = 5'd0`.
- Sub-module `hazard_perf_counters` is instantiated only under `HAZARD_PERF_EN`. Its inputs are the three event strobes plus `clk` and `rst`.
- FSM, load-use compare and watchdog stay in `hazard_ctrl`.

## Test plan
- **Load-use:** `ex_mem_read=1`, `ex_rd=5`, `id_rs1=5`, `id_uses_rs1=1` -> for exactly one cycle `pc_stall=1`, `if_id_stall=1`, `id_ex_flush=1`. Repeating with `ex_rd=0` -> no stall.
- **Branch flush:** `br_taken=1` for one cycle in RUN -> `if_id_flush=1` and `id_ex_flush=1` that cycle; state is `HZ_FLUSH` next cycle. A matching load-use in the `HZ_FLUSH` cycle -> no stall.
- **Memory wait with branch:** `mem_req=1`, `mem_ready=0` for 3 cycles with `br_taken=1` throughout -> all stalls 1 and no flush for 3 cycles. On the 4th cycle (`mem_ready=1`) -> stalls 0, both flushes 1.
- **Watchdog:** with `MEM_TIMEOUT=4`, hold the memory wait for 6 cycles -> `mem_timeout_err` rises after 4 wait cycles and stays 1 after the wait ends until `rst`.
- **Reset mid-operation:** assert `rst` during a memory wait -> both flushes 1 and stalls 0 in that cycle. After release, state is `HZ_RUN`, the counter is 0, and the perf counters are 0 with `HAZARD_PERF_EN` defined.
- **Priority:** `br_taken=1` with a simultaneous load-use match -> flush only, with `perf_flush_count` +1 and `perf_load_use_count` unchanged.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared types and constants for the pipeline control blocks.
//   hz_state_e : hazard controller FSM state (RUN / MEM_WAIT / FLUSH)
//   REG_ZERO   : architectural zero register index (never a real hazard)
//   src_match  : "this source operand is read and equals rd" helper
// -----------------------------------------------------------------------------
package control_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic src_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] rd);
        return uses && (src == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Pipeline -> controller : id_rs1/2, id_uses_rs1/2, ex_rd, ex_mem_read,
//                            br_taken, mem_req, mem_ready
//   Controller -> pipeline : pc/if_id/id_ex/ex_mem stalls, if_id/id_ex
//                            flushes, mem_timeout_err
// Modports: master = pipeline side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_stall;
    logic       ex_mem_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_timeout_err;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               br_taken, mem_req, mem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_timeout_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               br_taken, mem_req, mem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_timeout_err
    );

endinterface

// File: rtl/hazard_ctrl_perf_counters.sv
// -----------------------------------------------------------------------------
// hazard_perf_counters
// Three saturating 32-bit event counters for the hazard controller.
// Present only when HAZARD_PERF_EN is defined.
//   clk, rst              : clock, synchronous active-high reset
//   i_stall_evt           : pc_stall asserted this cycle
//   i_flush_evt           : branch flush this cycle
//   i_load_use_evt        : load-use stall this cycle
//   o_perf_stall_cycles   : count of stall cycles
//   o_perf_flush_count    : count of branch flushes
//   o_perf_load_use_count : count of load-use stalls
// -----------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
module hazard_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall_evt,
    input  logic        i_flush_evt,
    input  logic        i_load_use_evt,
    output logic [31:0] o_perf_stall_cycles,
    output logic [31:0] o_perf_flush_count,
    output logic [31:0] o_perf_load_use_count
);

    logic [31:0] r_stall;
    logic [31:0] r_flush;
    logic [31:0] r_lu;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
            r_flush <= '0;
            r_lu    <= '0;
        end else begin
            // Saturate rather than wrap so a long run never reads as "few events".
            if (i_stall_evt    && r_stall != '1) r_stall <= r_stall + 32'd1;
            if (i_flush_evt    && r_flush != '1) r_flush <= r_flush + 32'd1;
            if (i_load_use_evt && r_lu    != '1) r_lu    <= r_lu + 32'd1;
        end
    end

    assign o_perf_stall_cycles   = r_stall;
    assign o_perf_flush_count    = r_flush;
    assign o_perf_load_use_count = r_lu;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage core.
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_ctrl_if.slave (ID/EX operand info, branch, data-memory
//              handshake in; stall/flush enables and watchdog error out)
//   perf_*   : saturating event counters (only with HAZARD_PERF_EN defined)
// Priority: memory wait > branch flush > load-use.
// Stall/flush outputs are combinational; state, watchdog counter and error
// flag are registered. Optional macro: HAZARD_PERF_EN.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_load_use_count
`endif
);

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    hz_state_e   r_state;
    hz_state_e   w_state_next;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_next;
    logic        r_err;

    logic w_mem_wait;
    logic w_load_use;
    logic w_wait_stall;
    logic w_branch_flush;
    logic w_lu_stall;

    assign w_mem_wait = hz.mem_req && !hz.mem_ready;

    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != REG_ZERO) &&
                        (src_match(hz.id_uses_rs1, hz.id_rs1, hz.ex_rd) ||
                         src_match(hz.id_uses_rs2, hz.id_rs2, hz.ex_rd));

    // Reset overrides everything; a memory wait masks branch and load-use.
    // A release cycle in HZ_MEM_WAIT evaluates like HZ_RUN, so only HZ_FLUSH
    // (ID holds a bubble) suppresses load-use.
    assign w_wait_stall   = !rst && w_mem_wait;
    assign w_branch_flush = !rst && !w_mem_wait && hz.br_taken;
    assign w_lu_stall     = !rst && !w_mem_wait && !hz.br_taken && w_load_use &&
                            (r_state != HZ_FLUSH);

    assign hz.pc_stall        = w_wait_stall | w_lu_stall;
    assign hz.if_id_stall     = w_wait_stall | w_lu_stall;
    assign hz.id_ex_stall     = w_wait_stall;
    assign hz.ex_mem_stall    = w_wait_stall;
    assign hz.if_id_flush     = rst | w_branch_flush;
    assign hz.id_ex_flush     = rst | w_branch_flush | w_lu_stall;
    assign hz.mem_timeout_err = r_err;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state_next = HZ_RUN;
        if (w_mem_wait)        w_state_next = HZ_MEM_WAIT;
        else if (hz.br_taken)  w_state_next = HZ_FLUSH;
    end

    // Watchdog counts consecutive wait cycles and saturates at the limit.
    always_comb begin
        w_wait_cnt_next = '0;
        if (w_mem_wait) begin
            w_wait_cnt_next = (r_wait_cnt == TIMEOUT) ? r_wait_cnt : r_wait_cnt + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HZ_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            // Sticky: set on the edge the counter reaches the limit.
            if (w_wait_cnt_next == TIMEOUT) r_err <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_counters u_perf (
        .clk                   (clk),
        .rst                   (rst),
        .i_stall_evt           (hz.pc_stall),
        .i_flush_evt           (w_branch_flush),
        .i_load_use_evt        (w_lu_stall),
        .o_perf_stall_cycles   (perf_stall_cycles),
        .o_perf_flush_count    (perf_flush_count),
        .o_perf_load_use_count (perf_load_use_count)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4). Each step drives inputs,
// queues the expected output vector, and compares it on the falling edge.
// Output vector order: {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
//                       if_id_flush, id_ex_flush, mem_timeout_err}
// Perf counter checks are compiled in when HAZARD_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import control_pkg::*;

    localparam logic [6:0] E_IDLE = 7'b0000000;
    localparam logic [6:0] E_LU   = 7'b1100010;
    localparam logic [6:0] E_BR   = 7'b0000110;
    localparam logic [6:0] E_WAIT = 7'b1111000;
    localparam logic [6:0] E_RST  = 7'b0000110;
    localparam logic [6:0] E_ERR  = 7'b0000001;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    sb_entry_t sb_q[$];

    hazard_ctrl_if hz_if ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
    logic [31:0] perf_load_use_count;
    logic [31:0] flush_before;
    logic [31:0] lu_before;
`endif

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if.slave)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles   (perf_stall_cycles),
        .perf_flush_count    (perf_flush_count),
        .perf_load_use_count (perf_load_use_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {hz_if.pc_stall, hz_if.if_id_stall, hz_if.id_ex_stall,
                hz_if.ex_mem_stall, hz_if.if_id_flush, hz_if.id_ex_flush,
                hz_if.mem_timeout_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hz_if.id_rs1      = 5'd0;
        hz_if.id_rs2      = 5'd0;
        hz_if.id_uses_rs1 = 1'b0;
        hz_if.id_uses_rs2 = 1'b0;
        hz_if.ex_rd       = 5'd0;
        hz_if.ex_mem_read = 1'b0;
        hz_if.br_taken    = 1'b0;
        hz_if.mem_req     = 1'b0;
        hz_if.mem_ready   = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_rd       = rd;
        hz_if.id_rs1      = rd;
        hz_if.id_uses_rs1 = 1'b1;
    endtask

    // Inputs are already applied; queue the expectation, compare mid-cycle,
    // then move to just after the next rising edge.
    task automatic step(input string tag, input logic [6:0] exp);
        sb_entry_t e;
        sb_q.push_back('{tag: tag, exp: exp});
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.tag, {25'd0, outs()}, {25'd0, e.exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step("reset_outputs", E_RST);
        check("reset_state", 32'(dut.r_state), 32'(HZ_RUN));
        check("reset_cnt", 32'(dut.r_wait_cnt), 32'd0);
        rst = 1'b0;

        step("idle", E_IDLE);

        // Load-use on rs1, one cycle only.
        set_load_use(5'd5);
        step("lu_rs1", E_LU);
        idle();
        step("lu_gone", E_IDLE);

        // Destination x0 is never a hazard.
        set_load_use(5'd0);
        step("lu_x0", E_IDLE);

        // rs2 path, then rs2 match but not used.
        idle();
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_rd       = 5'd7;
        hz_if.id_rs2      = 5'd7;
        hz_if.id_uses_rs2 = 1'b1;
        step("lu_rs2", E_LU);
        hz_if.id_uses_rs2 = 1'b0;
        step("lu_rs2_unused", E_IDLE);

        // Branch flush, then load-use suppressed in HZ_FLUSH.
        idle();
        hz_if.br_taken = 1'b1;
        step("branch", E_BR);
        check("state_flush", 32'(dut.r_state), 32'(HZ_FLUSH));
        idle();
        set_load_use(5'd5);
        step("lu_in_flush", E_IDLE);
        step("lu_after_flush", E_LU);

        // Branch and load-use together: flush only.
`ifdef HAZARD_PERF_EN
        flush_before = perf_flush_count;
        lu_before    = perf_load_use_count;
`endif
        hz_if.br_taken = 1'b1;
        step("br_over_lu", E_BR);
`ifdef HAZARD_PERF_EN
        check("perf_flush_inc", perf_flush_count, flush_before + 32'd1);
        check("perf_lu_same", perf_load_use_count, lu_before);
`endif
        idle();
        step("flush_idle", E_IDLE);

        // Memory wait with branch held: stall three cycles, flush on release.
        hz_if.mem_req  = 1'b1;
        hz_if.br_taken = 1'b1;
        for (int i = 0; i < 3; i++) step("wait_br", E_WAIT);
        hz_if.mem_ready = 1'b1;
        step("release_br", E_BR);
        check("release_state", 32'(dut.r_state), 32'(HZ_FLUSH));

        // Ready in the same cycle as the request is not a wait.
        hz_if.br_taken = 1'b0;
        step("req_ready_same", E_IDLE);
        check("cnt_no_wait", 32'(dut.r_wait_cnt), 32'd0);

        // Release via mem_req dropping, with load-use on the release cycle.
        idle();
        hz_if.mem_req = 1'b1;
        step("wait_one", E_WAIT);
        hz_if.mem_req = 1'b0;
        set_load_use(5'd9);
        step("release_lu", E_LU);

        // Watchdog: 6 wait cycles, error visible from the 5th.
        idle();
        hz_if.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step("wd_wait", E_WAIT);
        for (int i = 0; i < 2; i++) step("wd_err", E_WAIT | E_ERR);
        check("wd_cnt_sat", 32'(dut.r_wait_cnt), 32'd4);
        idle();
        step("wd_sticky", E_ERR);

        // Reset asserted in the middle of a wait.
        hz_if.mem_req = 1'b1;
        step("pre_rst_wait", E_WAIT | E_ERR);
        rst = 1'b1;
        step("rst_mid_wait", E_RST | E_ERR);
        rst = 1'b0;
        idle();
        check("post_rst_state", 32'(dut.r_state), 32'(HZ_RUN));
        check("post_rst_cnt", 32'(dut.r_wait_cnt), 32'd0);
`ifdef HAZARD_PERF_EN
        check("perf_stall_rst", perf_stall_cycles, 32'd0);
        check("perf_flush_rst", perf_flush_count, 32'd0);
        check("perf_lu_rst", perf_load_use_count, 32'd0);
`endif
        step("post_rst_idle", E_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
